// File: rtl/mem_sram_1r1w.sv
// 1R1W behavioural SRAM with lane write masks and a resettable read pipeline, READ_LAT cycles read latency.
// No backpressure: one read and one write accepted per cycle, results can't be stalled.
module mem_sram_1r1w #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int MASK_G = 8,
  parameter int READ_LAT = 1,
  parameter int BYPASS = 1,
  parameter logic [DATA_W-1:0] INIT_WORD = '0,
  parameter int TRACE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          W0_addr,
  input  logic                       W0_en,
  input  logic [DATA_W-1:0]          W0_data,
  input  logic [DATA_W/MASK_G-1:0]   W0_mask,
  input  logic [ADDR_W-1:0]          R0_addr,
  input  logic                       R0_en,
  output logic [DATA_W-1:0]          R0_data,
  output logic                       R0_valid
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MASK_W = DATA_W / MASK_G;

  if ((DATA_W % MASK_G) != 0 || READ_LAT < 1 || READ_LAT > 4 ||
      (BYPASS != 0 && BYPASS != 1) || (TRACE != 0 && TRACE != 1)) begin : g_bad_param
    $error("mem_sram_1r1w: illegal parameter combination");
  end

  // Array contents survive rst_n; only the time-zero image is INIT_WORD.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] pipe_d [READ_LAT];
  logic [READ_LAT-1:0] pipe_v;

  always_ff @(posedge clk) begin
    if (rst_n && W0_en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (W0_mask[i]) mem[W0_addr][i*MASK_G +: MASK_G] <= W0_data[i*MASK_G +: MASK_G];
      end
    end
  end

  always_comb begin
    rd_word = mem[R0_addr];
    if (BYPASS != 0 && W0_en && (W0_addr == R0_addr)) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (W0_mask[i]) rd_word[i*MASK_G +: MASK_G] = W0_data[i*MASK_G +: MASK_G];
      end
    end
  end

  // Data only advances behind a valid bit, so the output word holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= R0_en;
      if (R0_en) pipe_d[0] <= rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign R0_data  = pipe_d[READ_LAT-1];
  assign R0_valid = pipe_v[READ_LAT-1];

endmodule

// File: tb/tb_mem_sram_1r1w.sv
// Scoreboard bench: four instances cover init/latency, masking, bypass on/off, pipelining, reset and narrow geometry.
module tb_mem_sram_1r1w;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t q[1:4][$];

  logic        rst_n [1:4];
  logic [8:0]  waddr [1:3];
  logic [8:0]  raddr [1:3];
  logic        wen   [1:3];
  logic        ren   [1:3];
  logic        rv    [1:3];
  logic [63:0] wdata [1:3];
  logic [63:0] rdata [1:3];
  logic [7:0]  wmask [1:3];
  logic [3:0]  waddr4, raddr4;
  logic        wen4, ren4, rv4;
  logic [31:0] wdata4, rdata4;
  logic [1:0]  wmask4;

  mem_sram_1r1w #(.READ_LAT(1), .BYPASS(1), .INIT_WORD(64'h0001_0001_0001_0001)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .W0_addr(waddr[1]), .W0_en(wen[1]), .W0_data(wdata[1]),
    .W0_mask(wmask[1]), .R0_addr(raddr[1]), .R0_en(ren[1]), .R0_data(rdata[1]), .R0_valid(rv[1]));

  mem_sram_1r1w #(.READ_LAT(1), .BYPASS(0)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .W0_addr(waddr[2]), .W0_en(wen[2]), .W0_data(wdata[2]),
    .W0_mask(wmask[2]), .R0_addr(raddr[2]), .R0_en(ren[2]), .R0_data(rdata[2]), .R0_valid(rv[2]));

  mem_sram_1r1w #(.READ_LAT(3), .BYPASS(1)) u3 (
    .clk(clk), .rst_n(rst_n[3]), .W0_addr(waddr[3]), .W0_en(wen[3]), .W0_data(wdata[3]),
    .W0_mask(wmask[3]), .R0_addr(raddr[3]), .R0_en(ren[3]), .R0_data(rdata[3]), .R0_valid(rv[3]));

  mem_sram_1r1w #(.ADDR_W(4), .DATA_W(32), .MASK_G(16), .READ_LAT(2), .BYPASS(1)) u4 (
    .clk(clk), .rst_n(rst_n[4]), .W0_addr(waddr4), .W0_en(wen4), .W0_data(wdata4),
    .W0_mask(wmask4), .R0_addr(raddr4), .R0_en(ren4), .R0_data(rdata4), .R0_valid(rv4));

  function automatic int lat_of(input int k);
    return (k == 3) ? 3 : (k == 4) ? 2 : 1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [63:0] d);
    exp_t e;
    if (v !== 1'b1) return;
    if (q[k].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d_unexpected_valid: got valid with data %h at cycle %0d, expected none", k, d, cyc);
    end else begin
      e = q[k].pop_front();
      check($sformatf("u%0d_data", k), d, e.d);
      check($sformatf("u%0d_cycle", k), 64'(cyc), 64'(e.due));
    end
  endtask

  always @(negedge clk) begin
    mon(1, rv[1], rdata[1]);
    mon(2, rv[2], rdata[2]);
    mon(3, rv[3], rdata[3]);
    mon(4, rv4, {32'h0, rdata4});
  end

  task automatic rd_issue(input int k, input logic [8:0] a);
    if (k == 4) begin
      raddr4 = a[3:0];
      ren4 = 1'b1;
    end else begin
      raddr[k] = a;
      ren[k] = 1'b1;
    end
  endtask

  task automatic rd(input int k, input logic [8:0] a, input logic [63:0] e);
    exp_t x;
    x.d = e;
    x.due = cyc + lat_of(k);
    q[k].push_back(x);
    rd_issue(k, a);
  endtask

  task automatic wr(input int k, input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
    if (k == 4) begin
      waddr4 = a[3:0];
      wdata4 = d[31:0];
      wmask4 = m[1:0];
      wen4 = 1'b1;
    end else begin
      waddr[k] = a;
      wdata[k] = d;
      wmask[k] = m;
      wen[k] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    for (int k = 1; k <= 3; k++) begin
      ren[k] = 1'b0;
      wen[k] = 1'b0;
    end
    ren4 = 1'b0;
    wen4 = 1'b0;
  endtask

  initial begin
    for (int k = 1; k <= 4; k++) rst_n[k] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      waddr[k] = '0; raddr[k] = '0; wen[k] = 1'b0; ren[k] = 1'b0;
      wdata[k] = '0; wmask[k] = '0;
    end
    waddr4 = '0; raddr4 = '0; wen4 = 1'b0; ren4 = 1'b0; wdata4 = '0; wmask4 = '0;
    tick();
    tick();

    for (int k = 1; k <= 3; k++) begin
      check($sformatf("u%0d_reset_valid", k), 64'(rv[k]), 64'h0);
      check($sformatf("u%0d_reset_data", k), rdata[k], 64'h0);
    end
    check("u4_reset_valid", 64'(rv4), 64'h0);
    check("u4_reset_data", {32'h0, rdata4}, 64'h0);
    for (int k = 1; k <= 4; k++) rst_n[k] = 1'b1;

    // Init image and single-cycle latency, then hold.
    rd(1, 9'h1FF, 64'h0001_0001_0001_0001);
    tick();
    tick();
    check("u1_hold_valid", 64'(rv[1]), 64'h0);
    check("u1_hold_data", rdata[1], 64'h0001_0001_0001_0001);

    // Masked writes over two init images, then a zero-mask no-op.
    wr(1, 9'd5, 64'h1122_3344_5566_7788, 8'b1010_0101);
    wr(2, 9'd5, 64'h1122_3344_5566_7788, 8'b1010_0101);
    tick();
    rd(1, 9'd5, 64'h1101_3301_0066_0088);
    rd(2, 9'd5, 64'h1100_3300_0066_0088);
    tick();
    wr(2, 9'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    tick();
    rd(2, 9'd5, 64'h1100_3300_0066_0088);
    tick();

    // Same-edge write/read collision with and without bypass.
    wr(1, 9'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    wr(2, 9'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    tick();
    wr(1, 9'd7, 64'h5555_5555_5555_5555, 8'h0F);
    wr(2, 9'd7, 64'h5555_5555_5555_5555, 8'h0F);
    rd(1, 9'd7, 64'hAAAA_AAAA_5555_5555);
    rd(2, 9'd7, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    rd(1, 9'd7, 64'hAAAA_AAAA_5555_5555);
    rd(2, 9'd7, 64'hAAAA_AAAA_5555_5555);
    tick();

    // Streaming reads through a 3-deep pipeline; a later write must not disturb in-flight data.
    for (int a = 0; a < 4; a++) begin
      wr(3, 9'(a), 64'(a), 8'hFF);
      tick();
    end
    rd(3, 9'd0, 64'd0);
    tick();
    rd(3, 9'd1, 64'd1);
    tick();
    rd(3, 9'd2, 64'd2);
    wr(3, 9'd1, 64'h99, 8'hFF);
    tick();
    rd(3, 9'd3, 64'd3);
    tick();
    rd(3, 9'd1, 64'h99);
    tick();
    repeat (4) tick();

    // Reset with a read in flight: output clears at once and the read never emerges.
    rd_issue(3, 9'd3);
    tick();
    tick();
    rst_n[3] = 1'b0;
    wr(3, 9'd3, 64'hFF, 8'hFF);
    #1;
    check("u3_midreset_valid", 64'(rv[3]), 64'h0);
    check("u3_midreset_data", rdata[3], 64'h0);
    tick();
    tick();
    rst_n[3] = 1'b1;
    repeat (6) tick();
    rd(3, 9'd3, 64'd3);
    tick();

    // Narrow geometry with 16-bit lanes; simultaneous write and read to different addresses.
    wr(4, 9'd15, 64'hDEAD_BEEF, 8'b10);
    tick();
    rd(4, 9'd15, 64'h0000_0000_DEAD_0000);
    wr(4, 9'd3, 64'h1234_5678, 8'b11);
    tick();
    rd(4, 9'd3, 64'h0000_0000_1234_5678);
    tick();
    rd(4, 9'd0, 64'h0);
    tick();

    repeat (8) tick();
    for (int k = 1; k <= 4; k++) check($sformatf("u%0d_pending", k), 64'(q[k].size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
